// File: rtl/pipeline_rx_fifo.sv
// Receive buffer: captures the valid-only stream from pipeline and re-presents it FWFT with valid/ready.
// One-cycle push-to-output latency; no backpressure upstream, so overflowing words are dropped and counted.
module pipeline_rx_fifo #(
  parameter int DATA_WIDTH         = 8,
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      input_data,
  input  logic                       input_valid,
  output logic [DATA_WIDTH-1:0]      output_data,
  output logic                       output_valid,
  input  logic                       output_ready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       almost_full,
  output logic                       overflow,
  output logic [7:0]                 drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(ALMOST_FULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  drop;

  assign output_valid = (fill_level != '0);
  assign pop          = output_valid && output_ready;
  // A full queue still takes a word when the head leaves in the same cycle.
  assign push         = input_valid && ((fill_level < DEPTH_L) || pop);
  assign drop         = input_valid && !push;
  assign almost_full  = (fill_level >= AF_L);
  assign output_data  = output_valid ? mem[rd_ptr] : '0;

  // Storage cells are not reset; output_data is gated by output_valid instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= input_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_rx_fifo.sv
// Scoreboard bench for pipeline_rx_fifo: stimulus queues expected words, a negedge monitor checks pops.
module tb_pipeline_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] input_data = 8'h00;
  logic       input_valid = 1'b0;
  logic [7:0] output_data;
  logic       output_valid;
  logic       output_ready = 1'b0;
  logic [4:0] fill_level;
  logic       almost_full;
  logic       overflow;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  pipeline_rx_fifo #(
    .DATA_WIDTH(8),
    .DEPTH(16),
    .ALMOST_FULL_THRESH(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .input_data(input_data),
    .input_valid(input_valid),
    .output_data(output_data),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .fill_level(fill_level),
    .almost_full(almost_full),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one word for one cycle; only words the queue must accept are expected at the output.
  task automatic push_word(input logic [7:0] d, input bit accepted);
    input_valid = 1'b1;
    input_data  = d;
    if (accepted) exp_q.push_back(d);
    tick();
    input_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    output_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (fill_level == 5'd0) break;
      tick();
    end
    output_ready = 1'b0;
    check({name, "_fill_empty"}, fill_level, 0);
    check({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid and ready are both high now.
  initial begin
    forever begin
      @(negedge clk);
      if (output_valid && output_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pop: got 0x%0h, expected no word", output_data);
        end else begin
          check("pop_data", output_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and single word
    repeat (20) tick();
    check("rst_valid", output_valid, 0);
    check("rst_data", output_data, 0);
    check("rst_fill", fill_level, 0);
    check("rst_af", almost_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drops", drop_count, 0);
    rst = 1'b0;
    output_ready = 1'b1;
    push_word(8'hDB, 1'b1);
    check("single_valid", output_valid, 1);
    check("single_data", output_data, 8'hDB);
    tick();
    check("single_valid_after", output_valid, 0);
    check("single_data_after", output_data, 0);
    output_ready = 1'b0;

    // Fill and overflow
    for (int i = 0; i < 16; i++) begin
      push_word(8'(i), 1'b1);
      check("fill_af", almost_full, (i + 1 >= 12) ? 1 : 0);
      check("fill_level", fill_level, i + 1);
    end
    push_word(8'hAA, 1'b0);
    check("ovf_fill", fill_level, 16);
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_count, 1);
    drain("drain1");
    check("ovf_sticky", overflow, 1);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_word(8'(i), 1'b1);
    output_ready = 1'b1;
    push_word(8'h55, 1'b1);
    output_ready = 1'b0;
    check("fullpp_fill", fill_level, 16);
    check("fullpp_drops", drop_count, 1);

    // Drop counter saturation
    input_valid = 1'b1;
    input_data  = 8'hEE;
    repeat (300) tick();
    input_valid = 1'b0;
    check("sat_drops", drop_count, 255);
    check("sat_ovf", overflow, 1);
    check("sat_fill", fill_level, 16);
    drain("drain2");

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) push_word(8'h31 + 8'(i), 1'b1);
    check("ar_fill_pre", fill_level, 5);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("ar_valid", output_valid, 0);
    check("ar_data", output_data, 0);
    check("ar_fill", fill_level, 0);
    check("ar_drops", drop_count, 0);
    check("ar_ovf", overflow, 0);
    tick();
    rst = 1'b0;
    output_ready = 1'b1;
    push_word(8'h77, 1'b1);
    check("ar_next_data", output_data, 8'h77);
    tick();
    output_ready = 1'b0;
    check("ar_sb_empty", exp_q.size(), 0);

    // Pointer wrap with random ready, occupancy kept below full
    for (int i = 0; i < 40; i++) begin
      output_ready = (fill_level >= 5'd12) ? 1'b1 : 1'($urandom_range(0, 1));
      push_word(8'h80 + 8'(i), 1'b1);
    end
    check("wrap_not_full", (fill_level < 5'd16) ? 1 : 0, 1);
    drain("wrap");
    check("wrap_drops", drop_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_rx_fifo.md
# pipeline_rx_fifo

Receive buffer directly downstream of `pipeline`. It captures the valid-only stream (`output_data`/`output_valid`) from `pipeline`, which has no backpressure, and re-presents it to the consumer with a valid/ready handshake. It stores up to DEPTH words in first-word-fall-through order. Words that arrive when no slot is free are dropped and counted, so loss is visible to the bench and to software.

## Interface
- `DATA_WIDTH`, 8, width of each data word; matches the `pipeline` data width.
- `DEPTH`, 16, storage depth in words; must be a power of two and at least 2.
- `ALMOST_FULL_THRESH`, 12, fill level at or above which `almost_full` is asserted; range 1..DEPTH.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `input_data`  in  DATA_WIDTH  word from `pipeline` `output_data`.
- `input_valid`  in  1  push strobe from `pipeline` `output_valid`.
- `output_data`  out  DATA_WIDTH  head-of-queue word; forced to 0 when `output_valid`=0.
- `output_valid`  out  1  queue is non-empty.
- `output_ready`  in  1  consumer accepts the head word.
- `fill_level`  out  $clog2(DEPTH)+1  current number of stored words, 0..DEPTH.
- `almost_full`  out  1  `fill_level` >= ALMOST_FULL_THRESH.
- `overflow`  out  1  sticky: set when any word has been dropped since reset.
- `drop_count`  out  8  number of dropped words, saturating at 255.

## Operation
- Storage is a register array with write pointer `wr_ptr` and read pointer `rd_ptr`. Each pointer is $clog2(DEPTH) bits wide and wraps modulo DEPTH. A separate occupancy counter produces `fill_level`.
- pop = `output_valid` AND `output_ready`.
- push = `input_valid` AND (`fill_level` < DEPTH OR pop). A full queue therefore still accepts a word in the same cycle as a pop.
- drop = `input_valid` AND NOT push.
- On push: mem[`wr_ptr`] <= `input_data`; `wr_ptr` increments.
- On pop: `rd_ptr` increments.
- `fill_level` update per cycle:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on both or neither.
- On drop: `overflow` <= 1; `drop_count` increments unless it already equals 255.
- `output_data` = mem[`rd_ptr`] when `output_valid`=1, otherwise 0.
- `output_valid` = (`fill_level` != 0).
- `almost_full` is a combinational compare of `fill_level` against ALMOST_FULL_THRESH.
- `output_ready` while `output_valid`=0 has no effect.
- The block has no flow control toward `pipeline`; loss is reported only through `overflow` and `drop_count`.

## Timing
- Reset is asynchronous. While `rst`=1, all of the following hold regardless of `clk`:
  - `wr_ptr`=0, `rd_ptr`=0, `fill_level`=0;
  - `output_valid`=0, `output_data`=0;
  - `almost_full`=0, `overflow`=0, `drop_count`=0.
- Stored contents are discarded on reset. Memory cells need no reset because `output_data` is gated.
- Reset asserted mid-operation clears all of the above immediately, without waiting for a clock edge. The first push is accepted on the first rising edge with `rst`=0.
- Latency: a word pushed at edge N into an empty queue appears on `output_data` with `output_valid`=1 after edge N, i.e. during cycle N+1. It can be popped at edge N+1.
- Back-to-back push and pop with `output_ready` held at 1 gives one word per cycle, with `fill_level` steady at 1.
- Simultaneous push and pop at `fill_level`=DEPTH: the head word is consumed, the new word is stored, `fill_level` stays DEPTH, and nothing is dropped.
- Simultaneous push and pop at `fill_level`=0 is impossible, because `output_valid`=0 so no pop occurs. The push proceeds.
- `overflow` and `drop_count` update at the edge on which the drop occurs.

## Test plan
- Reset and single word:
  - Stimulus: hold `rst`=1 for 20 clocks and check every output is 0. Release reset, push 0xDB for one cycle with `output_ready`=1.
  - Response: the next cycle shows `output_valid`=1 and `output_data`=0xDB. The cycle after that shows `output_valid`=0 and `output_data`=0.
- Fill and overflow:
  - Stimulus: `output_ready`=0. Push 0x00..0x0F on consecutive cycles, then push 0xAA.
  - Response: `almost_full` rises after the 12th push. `fill_level`=16 after the 16th push. 0xAA is dropped, giving `overflow`=1 and `drop_count`=1.
  - Then raise `output_ready`: the queue drains 0x00..0x0F in order, ends with `fill_level`=0, and `overflow` stays 1.
- Full with simultaneous push and pop:
  - Stimulus: with the queue full of 0x00..0x0F, push 0x55 in the same cycle as a pop.
  - Response: 0x00 is consumed, `fill_level` stays 16, `drop_count` is unchanged. The drain order ends with 0x0F, then 0x55.
- Drop counter saturation:
  - Stimulus: with the queue full and `output_ready`=0, hold `input_valid`=1 for 300 cycles.
  - Response: `drop_count`=255 and `overflow`=1.
- Asynchronous reset mid-stream:
  - Stimulus: with `fill_level`=5, assert `rst` between clock edges.
  - Response: `output_valid`, `fill_level` and `drop_count` are 0 before the next edge. After release, the next word pushed is the next word output.
- Pointer wrap:
  - Stimulus: stream 40 words (0x80..0xA7) through `pipeline` with PIPELINE_LENGTH=16, using random `output_ready`. Keep `fill_level` below 16.
  - Response: output order is identical to input order and `drop_count`=0.
